// File: rtl/l2_cache_ctrl.sv
// L2 line controller: round-robin I/D arbitration, lookup, dirty writeback and refill.
// Optional hit/miss/writeback counters are compiled in when L2_STAT_EN is defined.
module l2_cache_ctrl #(
   parameter int ADDR_W = 28,
   parameter int IDX_W  = 5,
   parameter int DATA_W = 128
`ifdef L2_STAT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_read,
   input  logic [ADDR_W-1:0]              i_addr,
   output logic                           i_ready,
   output logic [DATA_W-1:0]              i_rdata,
   input  logic                           d_read,
   input  logic                           d_write,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           d_ready,
   output logic [DATA_W-1:0]              d_rdata,
   output logic [ADDR_W-1:0]              sram_addr,
   output logic [DATA_W+ADDR_W-IDX_W+2:0] sram_wdata,
   output logic                           sram_write,
   output logic                           sram_id,
   input  logic [DATA_W+ADDR_W-IDX_W+2:0] sram_rdata,
   input  logic                           sram_hit,
   output logic                           mem_read,
   output logic                           mem_write,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_ready,
   output logic [2:0]                     state_dbg
`ifdef L2_STAT_EN
   ,
   output logic [CNT_W-1:0]               hit_cnt,
   output logic [CNT_W-1:0]               miss_cnt,
   output logic [CNT_W-1:0]               wb_cnt
`endif
);
   localparam int TAG_W  = ADDR_W - IDX_W;
   localparam int LINE_W = DATA_W + TAG_W + 3;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, ALLOC, DONE} state_t;

   // Handshake: a requester holds read/write until its one-cycle ready pulse and
   // may change the request in the following cycle; memory holds read/write until mem_ready.
   state_t              state, state_nx;
   logic                rr_ptr;      // 1 = I-side wins the next tie
   logic                grant_src;   // 1 = I-side transaction
   logic [ADDR_W-1:0]   g_addr;
   logic                g_write;
   logic [DATA_W-1:0]   g_wdata;
   logic [TAG_W-1:0]    v_tag;
   logic [DATA_W-1:0]   v_data;
   logic                d_req, grant_i, victim_dirty;
   logic [LINE_W-1:0]   dirty_line;
   logic                unused_rdata_id;

   assign d_req           = d_read | d_write;
   assign grant_i         = i_read & (~d_req | rr_ptr);
   assign victim_dirty    = sram_rdata[LINE_W-2] & sram_rdata[LINE_W-3];
   assign dirty_line      = {1'b0, 1'b1, 1'b1, g_addr[ADDR_W-1:IDX_W], g_wdata};
   assign unused_rdata_id = sram_rdata[LINE_W-1];
   assign state_dbg       = state;
   assign i_ready         = (state == DONE) & grant_src;
   assign d_ready         = (state == DONE) & ~grant_src;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b1;
         grant_src <= 1'b0;
         g_addr    <= '0;
         g_write   <= 1'b0;
         g_wdata   <= '0;
         v_tag     <= '0;
         v_data    <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (i_read || d_req) begin
               grant_src <= grant_i;
               g_addr    <= grant_i ? i_addr : d_addr;
               g_write   <= ~grant_i & d_write;
               g_wdata   <= d_wdata;
               if (i_read && d_req) rr_ptr <= ~rr_ptr;
            end
            LOOKUP: if (sram_hit) begin
               if (!g_write) begin
                  if (grant_src) i_rdata <= sram_rdata[DATA_W-1:0];
                  else           d_rdata <= sram_rdata[DATA_W-1:0];
               end
            end else begin
               v_tag  <= sram_rdata[DATA_W+TAG_W-1:DATA_W];
               v_data <= sram_rdata[DATA_W-1:0];
            end
            ALLOC: if (mem_ready) begin
               if (grant_src) i_rdata <= mem_rdata;
               else           d_rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      sram_addr  = '0;
      sram_id    = 1'b0;
      sram_write = 1'b0;
      sram_wdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (state != IDLE) begin
         sram_addr = g_addr;
         sram_id   = grant_src;
      end
      case (state)
         IDLE:   if (i_read || d_req) state_nx = LOOKUP;
         LOOKUP: begin
            if (sram_hit) begin
               if (g_write) begin
                  sram_write = 1'b1;
                  sram_wdata = dirty_line;
               end
               state_nx = DONE;
            end else if (victim_dirty) begin
               state_nx = WB;
            end else if (g_write) begin
               // Full-line write: a clean victim is simply overwritten, no fetch.
               sram_write = 1'b1;
               sram_wdata = dirty_line;
               state_nx   = DONE;
            end else begin
               state_nx = ALLOC;
            end
         end
         WB: begin
            mem_write = 1'b1;
            mem_addr  = {v_tag, g_addr[IDX_W-1:0]};
            mem_wdata = v_data;
            if (mem_ready) begin
               if (g_write) begin
                  sram_write = 1'b1;
                  sram_wdata = dirty_line;
                  state_nx   = DONE;
               end else begin
                  state_nx = ALLOC;
               end
            end
         end
         ALLOC: begin
            mem_read = 1'b1;
            mem_addr = g_addr;
            if (mem_ready) begin
               sram_write = 1'b1;
               sram_wdata = {grant_src, 1'b1, 1'b0, g_addr[ADDR_W-1:IDX_W], mem_rdata};
               state_nx   = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef L2_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         if (state == LOOKUP && sram_hit && hit_cnt != '1)    hit_cnt  <= hit_cnt + 1'b1;
         if (state == LOOKUP && !sram_hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 1'b1;
         if (state == WB && mem_ready && wb_cnt != '1)        wb_cnt   <= wb_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Bench for l2_cache_ctrl: behavioural line SRAM and memory, directed scenarios,
// then randomized traffic checked against a flat memory-image reference.
module tb_l2_cache_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         i_read, i_ready, d_read, d_write, d_ready;
   logic [27:0]  i_addr, d_addr, sram_addr, mem_addr;
   logic [127:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [153:0] sram_wdata, sram_rdata;
   logic         sram_write, sram_id, sram_hit;
   logic         mem_read, mem_write, mem_ready;
   logic [2:0]   state_dbg;

   l2_cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_write(sram_write),
      .sram_id(sram_id), .sram_rdata(sram_rdata), .sram_hit(sram_hit),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [183:0] obs, input logic [183:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Line SRAM: separate I/D halves, 32 sets x 2 ways, hit way or LRU victim on rdata.
   logic [153:0] sram_line [2][32][2] = '{default: '0};
   logic         lru [2][32] = '{default: 1'b0};
   logic         wr_way;
   logic [182:0] sram_log [$];

   always_comb begin
      logic [4:0] ix;
      ix         = sram_addr[4:0];
      sram_hit   = 1'b0;
      wr_way     = lru[sram_id][ix];
      sram_rdata = sram_line[sram_id][ix][lru[sram_id][ix]];
      for (int w = 0; w < 2; w++) begin
         if (sram_line[sram_id][ix][w][152] && sram_line[sram_id][ix][w][150:128] == sram_addr[27:5]) begin
            sram_hit   = 1'b1;
            wr_way     = w[0];
            sram_rdata = sram_line[sram_id][ix][w];
         end
      end
   end

   always @(posedge clk) begin
      if (sram_write) begin
         sram_line[sram_id][sram_addr[4:0]][wr_way] <= sram_wdata;
         lru[sram_id][sram_addr[4:0]] <= ~wr_way;
         sram_log.push_back({sram_id, sram_addr, sram_wdata});
      end
   end

   // Main memory image plus the D-side architectural view (latest value written by D).
   logic [127:0] mem_store [logic [27:0]];
   logic [127:0] shadow [logic [27:0]];
   logic [156:0] mem_log [$];

   function automatic logic [127:0] mem_init(input logic [27:0] a);
      return {4{4'hC, a}};
   endfunction

   function automatic logic [127:0] mem_val(input logic [27:0] a);
      return mem_store.exists(a) ? mem_store[a] : mem_init(a);
   endfunction

   function automatic logic [127:0] exp_d(input logic [27:0] a);
      return shadow.exists(a) ? shadow[a] : mem_val(a);
   endfunction

   int mem_lat  = 2;   // wait steps before mem_ready; negative selects random 0..3
   int mem_cnt  = -1;
   int mem_busy = 0;   // cycles a memory request was outstanding in this transaction

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (!rst_n || !(mem_read || mem_write)) begin
            mem_cnt = -1;
         end else begin
            check("mem_rd_wr_exclusive", {mem_read & mem_write}, 0);
            mem_busy++;
            if (mem_cnt < 0) mem_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            if (mem_cnt == 0) begin
               mem_ready = 1'b1;
               mem_cnt   = -1;
               if (mem_write) begin
                  check("wb_data_coherent", mem_wdata, exp_d(mem_addr));
                  mem_store[mem_addr] = mem_wdata;
                  mem_log.push_back({1'b1, mem_addr, mem_wdata});
               end else begin
                  mem_rdata = mem_val(mem_addr);
                  mem_log.push_back({1'b0, mem_addr, mem_rdata});
               end
            end else begin
               mem_cnt--;
            end
         end
      end
   end

   // One complete single-side transaction; returns read data and edges-to-ready.
   task automatic do_req(input logic side, input logic wr, input logic [27:0] a,
                         input logic [127:0] wd, output logic [127:0] rd, output int cyc);
      bit got;
      got      = 1'b0;
      rd       = 'x;
      cyc      = 0;
      mem_busy = 0;
      mem_log.delete();
      sram_log.delete();
      if (side) begin
         i_read = 1'b1; i_addr = a;
      end else begin
         d_read = ~wr; d_write = wr; d_addr = a; d_wdata = wd;
      end
      while (!got && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         check("no_cross_ready", side ? d_ready : i_ready, 0);
         if (side ? i_ready : d_ready) begin
            got = 1'b1;
            rd  = side ? i_rdata : d_rdata;
         end
      end
      check("ready_seen", got, 1);
      @(posedge clk); #1;
      check("ready_one_cycle", {i_ready, d_ready}, 0);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      if (!side && wr) shadow[a] = wd;
   endtask

   initial begin
      logic [127:0] rd, expd, wd;
      logic [27:0]  a;
      logic [2:0]   order;
      logic         side, wr;
      int           cyc, t, n;

      rst_n = 1'b1;
      i_read = 1'b0; i_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_state", state_dbg, 0);
      check("rst_ready", {i_ready, d_ready}, 0);
      check("rst_rdata", {i_rdata, d_rdata}, 0);
      check("rst_mem", {mem_read, mem_write, mem_addr, sram_write}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Cold read with a 3-cycle memory
      mem_store[28'h20] = {16{8'hA5}};
      do_req(1'b0, 1'b0, 28'h20, '0, rd, cyc);
      check("cold_rdata", rd, {16{8'hA5}});
      check("cold_latency", cyc, 5);
      check("cold_mem_ops", mem_log.size(), 1);
      check("cold_mem_read", mem_log[0], {1'b0, 28'h20, {16{8'hA5}}});
      check("cold_sram_ops", sram_log.size(), 1);
      check("cold_sram_line", sram_log[0], {1'b0, 28'h20, 1'b0, 1'b1, 1'b0, 23'h1, {16{8'hA5}}});

      // Read hit
      do_req(1'b0, 1'b0, 28'h20, '0, rd, cyc);
      check("hit_rdata", rd, {16{8'hA5}});
      check("hit_latency", cyc, 2);
      check("hit_no_mem", mem_log.size(), 0);
      check("hit_no_sram_wr", sram_log.size(), 0);

      // Write hit, then two reads in set 0 evict the dirty line
      do_req(1'b0, 1'b1, 28'h20, {32{4'h1}}, rd, cyc);
      check("wrhit_latency", cyc, 2);
      check("wrhit_no_mem", mem_log.size(), 0);
      check("wrhit_sram_line", sram_log[0], {1'b0, 28'h20, 1'b0, 1'b1, 1'b1, 23'h1, {32{4'h1}}});
      do_req(1'b0, 1'b0, 28'h40, '0, rd, cyc);
      check("fill40_rdata", rd, mem_init(28'h40));
      do_req(1'b0, 1'b0, 28'h60, '0, rd, cyc);
      check("evict_rdata", rd, mem_init(28'h60));
      check("evict_mem_ops", mem_log.size(), 2);
      check("evict_wb_first", mem_log[0], {1'b1, 28'h20, {32{4'h1}}});
      check("evict_refill", mem_log[1][156:128], {1'b0, 28'h60});
      check("evict_latency", cyc, 8);

      // Simultaneous I and D requests
      i_read = 1'b1; i_addr = 28'h1000; d_read = 1'b1; d_addr = 28'h40;
      n = 0; t = 0; order = '0;
      while (n < 3 && t < 100) begin
         @(posedge clk); #1;
         t++;
         check("both_ready_excl", {i_ready & d_ready}, 0);
         if (i_ready || d_ready) begin
            order[n] = i_ready;
            if (i_ready) check("both_i_rdata", i_rdata, mem_val(28'h1000));
            else         check("both_d_rdata", d_rdata, exp_d(28'h40));
            n++;
         end
      end
      check("both_count", n, 3);
      check("both_order_idi", order, 3'b101);
      @(posedge clk); #1;
      i_read = 1'b0; d_read = 1'b0;

      // I-side does not see D-side lines
      do_req(1'b1, 1'b0, 28'h20, '0, rd, cyc);
      check("iside_rdata", rd, {32{4'h1}});
      check("iside_mem_ops", mem_log.size(), 1);
      check("iside_mem_read", mem_log[0][156:128], {1'b0, 28'h20});
      check("iside_sram_line", sram_log[0], {1'b1, 28'h20, 1'b1, 1'b1, 1'b0, 23'h1, {32{4'h1}}});

      // Reset during a writeback
      mem_lat = 10;
      do_req(1'b0, 1'b1, 28'h25, {4{32'h2525_0001}}, rd, cyc);
      do_req(1'b0, 1'b1, 28'h45, {4{32'h4545_0002}}, rd, cyc);
      d_read = 1'b1; d_addr = 28'h65;
      t = 0;
      while (!mem_write && t < 30) begin
         @(posedge clk); #1;
         t++;
      end
      check("rstwb_started", mem_write, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstwb_mem_drop", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
      check("rstwb_outputs", {i_ready, d_ready, sram_write, state_dbg}, 0);
      check("rstwb_rdata", {i_rdata, d_rdata}, 0);
      d_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("rstwb_no_ready", {i_ready, d_ready, mem_write}, 0);
      end
      check("rstwb_no_mem_update", mem_store.exists(28'h25), 0);
      i_read = 1'b1; i_addr = 28'h1000; d_read = 1'b1; d_addr = 28'h45;
      t = 0;
      while (!(i_ready || d_ready) && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("rr_reset_grants_i", {i_ready, d_ready}, 2'b10);
      @(posedge clk); #1;
      i_read = 1'b0; d_read = 1'b0;

      // Randomized traffic
      mem_lat = -1;
      for (int k = 0; k < 200; k++) begin
         side = 1'($urandom_range(0, 1));
         wr   = ~side & 1'($urandom_range(0, 1));
         if (side) a = {23'(100 + $urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         else      a = {23'($urandom_range(0, 5)), 5'($urandom_range(0, 3))};
         wd   = {$urandom, $urandom, $urandom, $urandom};
         expd = side ? mem_val(a) : exp_d(a);
         do_req(side, wr, a, wd, rd, cyc);
         if (!wr) check("rnd_rdata", rd, expd);
         check("rnd_latency", cyc, 2 + mem_busy);
         check("rnd_sram_wr_max1", {sram_log.size() <= 1}, 1);
         if (wr) check("rnd_write_stored", sram_log.size(), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_cache_ctrl.md
Name: l2_cache_ctrl

Overview:
Controller that sequences the 2-way, 32-set L2 line SRAM (154-bit lines) between the two L1 caches (instruction and data) and main memory. It arbitrates the L1 requests round-robin, performs the lookup, writes back dirty victims and refills on read misses. Only one request is in flight at a time.

Parameters:
ADDR_W, 28, line address width (tag 23 + index 5)
IDX_W, 5, set index width (addr[4:0])
DATA_W, 128, line data width
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-side read request; held until i_ready
i_addr  in  28  I-side line address
i_ready  out  1  one-cycle completion pulse, I-side
i_rdata  out  128  I-side read data, valid when i_ready=1
d_read  in  1  D-side read request
d_write  in  1  D-side full-line write request; read and write are never both high
d_addr  in  28  D-side line address
d_wdata  in  128  D-side write data
d_ready  out  1  one-cycle completion pulse, D-side
d_rdata  out  128  D-side read data
sram_addr  out  28  to line SRAM addr_i
sram_wdata  out  154  {I/D, valid, dirty, tag[22:0], data[127:0]}
sram_write  out  1  line SRAM write strobe
sram_id  out  1  line SRAM I_D select: 1=instruction, 0=data
sram_rdata  in  154  line SRAM rdata_o; selected way or LRU victim
sram_hit  in  1  line SRAM hit_o
mem_read  out  1  memory line read; held until mem_ready
mem_write  out  1  memory line write; held until mem_ready
mem_addr  out  28  memory line address
mem_wdata  out  128  memory write data
mem_rdata  in  128  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse

Behaviour:
- Reset values, all registers async on rst_n low: state=IDLE; rr_ptr=I. All outputs 0: ready pulses, rdata, mem_*, sram_write. A reset mid-transaction abandons it immediately. mem_read and mem_write drop in the reset cycle, and no SRAM write occurs.
- States: IDLE, LOOKUP, WB, ALLOC, DONE.
- IDLE: the grant is registered into grant_src, g_addr, g_write and g_wdata, then the state moves to LOOKUP.
  - Only one side requesting: that side is granted.
  - Both requesting: the side named by rr_ptr is granted, and rr_ptr flips to the other side.
  - No request: stay in IDLE.
- SRAM drive: sram_addr = g_addr and sram_id = grant_src in every non-IDLE state.
- LOOKUP, hit and read: latch sram_rdata[127:0] as the response, then go to DONE.
- LOOKUP, hit and write: sram_write=1 with {0, 1, 1, tag, d_wdata}. This rewrites the hitting way and marks it dirty. Go to DONE.
- LOOKUP, miss: the victim is sram_rdata, the LRU way. Dirty means victim[152] and victim[151] are both set.
  - Victim dirty: go to WB.
  - Clean write miss: sram_write=1 with the dirty line. No fetch is needed because writes are full lines. Go to DONE.
  - Clean read miss: go to ALLOC.
- WB: mem_write=1, mem_addr={victim tag, g_addr[4:0]}, mem_wdata=victim data. The victim is latched on LOOKUP exit. Hold until mem_ready.
  - On mem_ready, a write request performs the dirty line write in that cycle, then goes to DONE.
  - On mem_ready, a read request goes to ALLOC.
- ALLOC: mem_read=1, mem_addr=g_addr. On mem_ready: sram_write=1 with {grant_src, 1, 0, g_addr[27:5], mem_rdata}; latch mem_rdata as the response; go to DONE.
- DONE: the granted side's ready is high for exactly one cycle with the registered rdata. rdata holds its value until the next response. Then return to IDLE.
- Requester rule: the requester changes or drops its request in the cycle after ready. IDLE samples it on the following edge.
- Latency from the edge that samples the request to ready:
  - hit, or clean write miss: 2 cycles
  - miss: 2 cycles + memory wait per WB/ALLOC phase
- mem_read and mem_write are never both high. sram_write is at most one cycle per transaction, except WB→ALLOC, which has no SRAM write in WB.
- Requests arriving while not in IDLE wait. A held request is never lost.

Optional Feature:
L2_STAT_EN: adds outputs hit_cnt[CNT_W-1:0], miss_cnt[CNT_W-1:0] and wb_cnt[CNT_W-1:0].
- Counters reset to 0 and saturate at all-ones.
- hit_cnt or miss_cnt increments once per LOOKUP exit; wb_cnt increments on a WB mem_ready.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Cold read: after reset, d_read with addr 0x0000020; memory returns 0xA5..A5 after 3 cycles → one mem_read to 0x0000020, sram_write with line {0,1,0,tag 0x000001,A5..}; d_ready pulses with rdata 0xA5..A5.
2. Read hit: repeat step 1's read → no mem activity; d_ready exactly 2 cycles after sampling; rdata 0xA5..A5.
3. Write hit then evict: d_write 0x0000020 with data 0x11..11 → dirty=1 and no memory access. Then reads to 0x0000040 and 0x0000060 (same set 0) → mem_write to 0x0000020 with 0x11..11 precedes the refill mem_read.
4. Simultaneous requests: i_read=d_read=1 for three back-to-back transactions → grant order I, D, I; each ready is one cycle on the correct side only.
5. I/D separation: I-side read of address 0x0000020 after D-side caching it → miss, so sram_id=1 and a memory fetch occurs.
6. Reset mid-WB: rst_n low while mem_write=1 → all outputs 0 immediately; the next request starts in IDLE; no ready pulse for the abandoned transaction.
